// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the radix-2 FFT stage sequencer.
package fft_pkg;

  localparam int N_LOG2 = 10;
  localparam int N      = 1 << N_LOG2;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    MUL   = 3'd3,
    ADD   = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } fsm_state_e;

  // Arithmetic right shift by one of each signed 16-bit half of a complex word.
  function automatic logic [DATA_W-1:0] half_asr(input logic [DATA_W-1:0] w);
    cplx_t c;
    cplx_t r;
    c    = w;
    r.re = c.re >>> 1;
    r.im = c.im >>> 1;
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake/bus bundle between the FFT stage sequencer and its RAM, ROM, butterfly and controller.
interface fft_seq_if
  import fft_pkg::*;
;
  logic                start;
  logic [3:0]          stage;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [N_LOG2-1:0]   rd_addr_a;
  logic [N_LOG2-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic [N_LOG2-2:0]   tf_addr;
  logic [31:0]         tf_data;
  logic                bf_enable;
  logic [31:0]         bf_a;
  logic [31:0]         bf_b;
  logic [31:0]         bf_tf;
  logic [31:0]         bf_y;
  logic [31:0]         bf_z;
  logic                wr_en;
  logic [N_LOG2-1:0]   wr_addr_a;
  logic [N_LOG2-1:0]   wr_addr_b;
  logic [DATA_W-1:0]   wr_data_a;
  logic [DATA_W-1:0]   wr_data_b;

  modport master (
    input  start, stage, rd_data_a, rd_data_b, tf_data, bf_y, bf_z,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tf_addr,
           bf_enable, bf_a, bf_b, bf_tf,
           wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    output start, stage, rd_data_a, rd_data_b, tf_data, bf_y, bf_z,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tf_addr,
           bf_enable, bf_a, bf_b, bf_tf,
           wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

endinterface

// File: rtl/fft_addr_gen.sv
// Combinational butterfly addressing: (k, s) -> operand pair addresses and twiddle index.
module fft_addr_gen
  import fft_pkg::*;
(
  input  logic [N_LOG2-2:0] k_i,
  input  logic [3:0]        s_i,
  output logic [N_LOG2-1:0] addr_a_o,
  output logic [N_LOG2-1:0] addr_b_o,
  output logic [N_LOG2-2:0] tf_idx_o
);

  localparam logic [N_LOG2-1:0] ONE = 1;

  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] j;
  logic [N_LOG2-1:0] grp;
  logic [3:0]        tf_sh;

  always_comb begin
    half     = ONE << s_i;
    j        = {1'b0, k_i} & (half - ONE);
    grp      = {1'b0, k_i} >> s_i;
    addr_a_o = (grp << (s_i + 4'd1)) | j;
    addr_b_o = addr_a_o + half;
    // j < half, so the shifted index always fits the ROM address width.
    tf_sh    = 4'(N_LOG2 - 1) - s_i;
    tf_idx_o = (N_LOG2-1)'(j << tf_sh);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Sequencer for one radix-2 DIT pass of the in-place FFT, driving butterflyx8.
// Build option: FFT_SEQ_SCALE_EN halves each y/z component before write-back.
module fft_stage_sequencer
  import fft_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  fft_seq_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_FETCH = 3'(FETCH);
  localparam logic [2:0] S_LOAD  = 3'(LOAD);
  localparam logic [2:0] S_MUL   = 3'(MUL);
  localparam logic [2:0] S_ADD   = 3'(ADD);
  localparam logic [2:0] S_WRITE = 3'(WRITE);
  localparam logic [2:0] S_DONE  = 3'(DONE);
  localparam logic [N_LOG2-2:0] K_ONE = 1;

  logic [2:0]        state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [N_LOG2-2:0] k_q, k_d;
  logic              rd_en_q, bf_en_q, wr_en_q, done_q;
  logic [31:0]       bf_a_q, bf_b_q, bf_tf_q;
  logic [N_LOG2-1:0] addr_a, addr_b;
  logic [N_LOG2-2:0] tf_idx;
  logic [DATA_W-1:0] wb_a, wb_b;

  fft_addr_gen u_addr_gen (
    .k_i      (k_q),
    .s_i      (s_q),
    .addr_a_o (addr_a),
    .addr_b_o (addr_b),
    .tf_idx_o (tf_idx)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.stage < 4'(N_LOG2))) begin
          state_d = S_FETCH;
          s_d     = bus.stage;
          k_d     = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_MUL;
      S_MUL:   state_d = S_ADD;
      S_ADD:   state_d = S_WRITE;
      S_WRITE: begin
        if (k_q == '1) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each is a clean flop output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rd_en_q <= 1'b0;
      bf_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      bf_a_q  <= '0;
      bf_b_q  <= '0;
      bf_tf_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rd_en_q <= (state_d == S_FETCH);
      bf_en_q <= (state_d == S_MUL);
      wr_en_q <= (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
      if (state_q == S_LOAD) begin
        bf_a_q  <= bus.rd_data_a;
        bf_b_q  <= bus.rd_data_b;
        bf_tf_q <= bus.tf_data;
      end
    end
  end

  // bf_y/bf_z settle on the edge that enters WRITE, so write data is taken straight through.
`ifdef FFT_SEQ_SCALE_EN
  assign wb_a = half_asr(bus.bf_y);
  assign wb_b = half_asr(bus.bf_z);
`else
  assign wb_a = bus.bf_y;
  assign wb_b = bus.bf_z;
`endif

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_en_q ? addr_a : '0;
  assign bus.rd_addr_b = rd_en_q ? addr_b : '0;
  assign bus.tf_addr   = rd_en_q ? tf_idx : '0;
  assign bus.bf_enable = bf_en_q;
  assign bus.bf_a      = bf_a_q;
  assign bus.bf_b      = bf_b_q;
  assign bus.bf_tf     = bf_tf_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr_a = wr_en_q ? addr_a : '0;
  assign bus.wr_addr_b = wr_en_q ? addr_b : '0;
  assign bus.wr_data_a = wr_en_q ? wb_a : '0;
  assign bus.wr_data_b = wr_en_q ? wb_b : '0;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer with behavioural RAM, twiddle ROM and butterfly.
module tb_fft_stage_sequencer;
  import fft_pkg::*;

  typedef struct {
    logic [9:0]  aa;
    logic [9:0]  ab;
    logic [8:0]  tf;
    logic [31:0] da;
    logic [31:0] db;
  } exp_t;

`ifdef FFT_SEQ_SCALE_EN
  localparam logic [31:0] KNOWN_Y = 32'h000A_0011;
  localparam logic [31:0] KNOWN_Z = 32'h0006_000F;
`else
  localparam logic [31:0] KNOWN_Y = 32'h0014_0022;
  localparam logic [31:0] KNOWN_Z = 32'h000C_001E;
`endif
  localparam int PASS_CYC = 5 * 512 + 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  fft_seq_if bus ();

  fft_stage_sequencer dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [0:1023];
  bit          written [0:1023];
  exp_t        rd_q[$];
  exp_t        wr_q[$];
  bit          armed = 1'b0;
  logic        fill_en = 1'b0;
  logic [31:0] fill_seed = 32'h0;
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic [31:0] bfm_b, bfm_tf;
  bit          bfm_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tf_rom(input logic [8:0] idx);
    return (idx == 9'd0) ? 32'h4000_0000 : {7'd0, idx, 7'h35, idx};
  endfunction

  // Q15 complex butterfly: y = a + b*tf, z = a - b*tf; returns {y, z}.
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
    logic signed [15:0] ar, ai, br, bi, tr, ti, mr, mi;
    logic signed [33:0] pr, pi;
    ar = a[31:16]; ai = a[15:0];
    br = b[31:16]; bi = b[15:0];
    tr = t[31:16]; ti = t[15:0];
    pr = 34'(br) * 34'(tr) - 34'(bi) * 34'(ti);
    pi = 34'(br) * 34'(ti) + 34'(bi) * 34'(tr);
    mr = 16'(pr >>> 15);
    mi = 16'(pi >>> 15);
    return {16'(ar + mr), 16'(ai + mi), 16'(ar - mr), 16'(ai - mi)};
  endfunction

  function automatic logic [31:0] wb(input logic [31:0] w);
`ifdef FFT_SEQ_SCALE_EN
    logic signed [15:0] re, im;
    re = w[31:16];
    im = w[15:0];
    return {16'(re >>> 1), 16'(im >>> 1)};
`else
    return w;
`endif
  endfunction

  always @(posedge clock) begin
    if (fill_en) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= {16'(i * 41) ^ fill_seed[31:16], 16'(i * 97) ^ fill_seed[15:0]};
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.wr_en) begin
      mem[bus.wr_addr_a] <= bus.wr_data_a;
      mem[bus.wr_addr_b] <= bus.wr_data_b;
    end
    if (bus.rd_en) begin
      bus.rd_data_a <= mem[bus.rd_addr_a];
      bus.rd_data_b <= mem[bus.rd_addr_b];
    end
    bus.tf_data <= tf_rom(bus.tf_addr);
  end

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bfm_pend <= 1'b0;
      bfm_b    <= '0;
      bfm_tf   <= '0;
      bus.bf_y <= '0;
      bus.bf_z <= '0;
    end else if (bus.bf_enable) begin
      bfm_b    <= bus.bf_b;
      bfm_tf   <= bus.bf_tf;
      bfm_pend <= 1'b1;
    end else if (bfm_pend) begin
      {bus.bf_y, bus.bf_z} <= bfly(bus.bf_a, bfm_b, bfm_tf);
      bfm_pend <= 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
    check_eq({tag, "_done"},  32'(bus.done), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    check_eq({tag, "_bf_en"}, 32'(bus.bf_enable), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    check_eq({tag, "_rd_addr"}, 32'({bus.rd_addr_a, bus.rd_addr_b}), 32'd0);
    check_eq({tag, "_tf_addr"}, 32'(bus.tf_addr), 32'd0);
    check_eq({tag, "_bf_a"},  bus.bf_a, 32'd0);
    check_eq({tag, "_bf_b"},  bus.bf_b, 32'd0);
    check_eq({tag, "_bf_tf"}, bus.bf_tf, 32'd0);
    check_eq({tag, "_wr_addr"}, 32'({bus.wr_addr_a, bus.wr_addr_b}), 32'd0);
    check_eq({tag, "_wr_da"}, bus.wr_data_a, 32'd0);
    check_eq({tag, "_wr_db"}, bus.wr_data_b, 32'd0);
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Expected reads/writes in butterfly order, enumerated as group-major, offset-minor.
  task automatic build_exp(input logic [3:0] st);
    int half, ngrp;
    exp_t e;
    logic [63:0] yz;
    half = 1 << st;
    ngrp = 512 / half;
    rd_q.delete();
    wr_q.delete();
    for (int g = 0; g < ngrp; g++) begin
      for (int j = 0; j < half; j++) begin
        e.aa = 10'(g * 2 * half + j);
        e.ab = 10'(g * 2 * half + j + half);
        e.tf = 9'(j * ngrp);
        yz   = bfly(mem[e.aa], mem[e.ab], tf_rom(e.tf));
        e.da = wb(yz[63:32]);
        e.db = wb(yz[31:0]);
        rd_q.push_back(e);
        wr_q.push_back(e);
      end
    end
  endtask

  task automatic run_pass(input logic [3:0] st, input bit mid, input bit known, input int nxt);
    int   cyc, done_cyc, done_cnt, last_busy, wr_cnt, dups;
    bit   first_wr;
    exp_t e;
    build_exp(st);
    foreach (written[i]) written[i] = 1'b0;
    if (!armed) begin
      @(negedge clock);
      bus.stage = st;
      bus.start = 1'b1;
    end
    armed = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    done_cyc = 0; done_cnt = 0; last_busy = 0; wr_cnt = 0; dups = 0; first_wr = 1'b1;
    for (cyc = 1; cyc <= PASS_CYC + 100; cyc++) begin
      if (cyc == 1) check_eq("fetch_c1", 32'(bus.rd_en), 32'd1);
      if (bus.rd_en) begin
        if (rd_q.size() == 0) check_eq("extra_rd", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          check_eq("rd_addr_a", 32'(bus.rd_addr_a), 32'(e.aa));
          check_eq("rd_addr_b", 32'(bus.rd_addr_b), 32'(e.ab));
          check_eq("tf_addr", 32'(bus.tf_addr), 32'(e.tf));
        end
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (written[bus.wr_addr_a]) dups++;
        if (written[bus.wr_addr_b]) dups++;
        written[bus.wr_addr_a] = 1'b1;
        written[bus.wr_addr_b] = 1'b1;
        if (wr_q.size() == 0) check_eq("extra_wr", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check_eq("wr_addr_a", 32'(bus.wr_addr_a), 32'(e.aa));
          check_eq("wr_addr_b", 32'(bus.wr_addr_b), 32'(e.ab));
          check_eq("wr_data_a", bus.wr_data_a, e.da);
          check_eq("wr_data_b", bus.wr_data_b, e.db);
        end
        if (known && first_wr) begin
          check_eq("known_y", bus.wr_data_a, KNOWN_Y);
          check_eq("known_z", bus.wr_data_b, KNOWN_Z);
        end
        first_wr = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!bus.busy) break;
      last_busy = cyc;
      if (mid && cyc == 100) begin
        bus.start = 1'b1;
        bus.stage = 4'd0;
      end else if (mid && cyc == 101) begin
        bus.start = 1'b0;
      end
      @(negedge clock);
    end
    check_eq("done_cycle", 32'(done_cyc), 32'(PASS_CYC));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("busy_last", 32'(last_busy), 32'(PASS_CYC));
    check_eq("busy_fall", 32'(cyc), 32'(PASS_CYC + 1));
    check_eq("wr_pulses", 32'(wr_cnt), 32'd512);
    check_eq("dup_writes", 32'(dups), 32'd0);
    check_eq("rd_left", 32'(rd_q.size()), 32'd0);
    check_eq("wr_left", 32'(wr_q.size()), 32'd0);
    if (nxt >= 0) begin
      bus.start = 1'b1;
      bus.stage = 4'(nxt);
      armed = 1'b1;
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, bad_wr;
    bus.start = 1'b0;
    bus.stage = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    rst_n = 1'b1;

    @(negedge clock);
    fill_seed = 32'h5A17_C3E9;
    fill_en = 1'b1;
    @(negedge clock);
    fill_en = 1'b0;
    poke(10'd0, 32'h0010_0020);
    poke(10'd1, 32'h0008_0004);

    run_pass(4'd0, 1'b0, 1'b1, -1);
    run_pass(4'd2, 1'b0, 1'b0, -1);
    run_pass(4'd9, 1'b1, 1'b0, -1);

    // Out-of-range stage must be ignored.
    @(negedge clock);
    bus.stage = 4'd10;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (10) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      @(negedge clock);
    end
    check_eq("bad_stage_busy", 32'(busy_cnt), 32'd0);
    check_eq("bad_stage_done", 32'(done_cnt), 32'd0);

    // Asynchronous reset while the butterfly is in MUL.
    bus.stage = 4'd1;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("mul_bf_en", 32'(bus.bf_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mul");
    busy_cnt = 0; done_cnt = 0; bad_wr = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      if (bus.wr_en) bad_wr++;
    end
    check_eq("rst_hold_busy", 32'(busy_cnt), 32'd0);
    check_eq("rst_hold_done", 32'(done_cnt), 32'd0);
    check_eq("rst_hold_wr", 32'(bad_wr), 32'd0);
    rst_n = 1'b1;

    run_pass(4'd5, 1'b0, 1'b0, -1);
    run_pass(4'd9, 1'b0, 1'b0, 3);
    run_pass(4'd3, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
